// File: rtl/lsu_mem_stage_pkg.sv
// Shared opcode/state encodings and decode helpers for the load/store memory stage.
// Imported by the stage top, its load extender and the bench.
package lsu_mem_stage_pkg;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LBU  = 4'd2,
    LSU_LH   = 4'd3,
    LSU_LHU  = 4'd4,
    LSU_LW   = 4'd5,
    LSU_SB   = 4'd6,
    LSU_SH   = 4'd7,
    LSU_SW   = 4'd8
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Unused opcode values behave as NONE so a stray encoding never touches memory.
  function automatic lsu_op_e decode_op(input logic [3:0] raw);
    lsu_op_e op;
    op = LSU_NONE;
    if (raw <= 4'd8) op = lsu_op_e'(raw);
    return op;
  endfunction

  function automatic logic is_load(input lsu_op_e op);
    return (op == LSU_LB) || (op == LSU_LBU) || (op == LSU_LH) ||
           (op == LSU_LHU) || (op == LSU_LW);
  endfunction

  function automatic logic is_store(input lsu_op_e op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
    logic half_op;
    logic word_op;
    half_op = (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
    word_op = (op == LSU_LW) || (op == LSU_SW);
    return (half_op && off[0]) || (word_op && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the load/store stage (master) and memory (slave).
// Handshake: master holds dm_req and all dm_* fields stable from the first request
// cycle until the cycle dm_ack is seen high; dm_rdata is valid in that same ack cycle.
interface lsu_mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/lsu_mem_stage_load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
// Purely combinational so the writeback mux can reuse it.
module load_extend
  import lsu_mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  lsu_op_e     op,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*off +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (op)
            LSU_LB:  ext = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: ext = {24'd0, byte_sel};
            LSU_LH:  ext = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: ext = {16'd0, half_sel};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one data-memory transaction per accepted request, with lane
// steering, load extension, misalignment trapping and ack-timeout detection.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [3:0]             mem_op,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   req_ready,
    output logic                   stall,
    output logic                   done,
    output logic [31:0]            rdata,
    output logic                   misalign,
    output logic                   bus_err,
    lsu_mem_stage_if.master        dm,
    output lsu_state_e             dbg_state
);

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    lsu_op_e     in_op;
    logic [31:0] load_val;
    logic        in_access;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    load_extend u_load_extend (
        .word (dm.dm_rdata),
        .off  (addr_q[1:0]),
        .op   (op_q),
        .ext  (load_val)
    );

    assign in_op = decode_op(mem_op);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = in_op;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    cnt_d      = 8'd0;
                    misalign_d = 1'b0;
                    bus_err_d  = 1'b0;
                    if (in_op == LSU_NONE) begin
                        state_d = ST_RESP;
                    end else if (is_misaligned(in_op, addr[1:0])) begin
                        misalign_d = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack arriving in the timeout cycle still completes the access.
                if (dm.dm_ack) begin
                    if (is_load(op_q)) rdata_d = load_val;
                    state_d = ST_RESP;
                end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    bus_err_d = 1'b1;
                    rdata_d   = 32'd0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= LSU_NONE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            cnt_q      <= 8'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Loads read the full word; the extender picks the lane afterwards.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = 32'd0;
        case (op_q)
            LSU_SB: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            LSU_SH: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            LSU_SW:  lane_wdata = wdata_q;
            default: lane_wdata = 32'd0;
        endcase
    end

    assign in_access   = (state_q == ST_ACCESS);
    assign dm.dm_req   = in_access;
    assign dm.dm_we    = in_access && is_store(op_q);
    assign dm.dm_be    = in_access ? lane_be : 4'b0000;
    assign dm.dm_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dm.dm_wdata = in_access ? lane_wdata : 32'd0;

    assign req_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_RESP);
    assign stall     = req_valid && !done;
    assign rdata     = rdata_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a 4-cycle ack timeout and a scripted memory.
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_ready;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_err;
  lsu_state_e  dbg_state;

  lsu_mem_stage_if dm_if();

  lsu_mem_stage #(.ACK_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .req_ready (req_ready),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .dm        (dm_if),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // results of the most recent run_op
  int          r_done_cyc;
  int          r_nreq;
  bit          r_stall_ok;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // One request; memory acks on its (ack_wait+1)-th request cycle, never if ack_wait < 0.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_wait, input logic [31:0] word);
    int  c;
    bit  got;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    mem_op    = op;
    addr      = a;
    wdata     = wd;
    r_stall_ok = 1'b1;
    r_nreq     = 0;
    r_done_cyc = -1;
    r_we = 1'b0; r_be = 4'd0; r_addr = 32'd0; r_wdata = 32'd0;
    got = 1'b0;
    c   = 0;
    #1;
    if (!stall) r_stall_ok = 1'b0;
    while (!got && c < 64) begin
      @(negedge clk);
      c++;
      dm_if.dm_ack = 1'b0;
      if (done) begin
        got = 1'b1;
        r_done_cyc = c;
        if (stall) r_stall_ok = 1'b0;
        req_valid = 1'b0;
        mem_op    = 4'd0;
      end else begin
        if (!stall) r_stall_ok = 1'b0;
        if (dm_if.dm_req) begin
          if (r_nreq == 0) begin
            r_we    = dm_if.dm_we;
            r_be    = dm_if.dm_be;
            r_addr  = dm_if.dm_addr;
            r_wdata = dm_if.dm_wdata;
          end
          r_nreq++;
          if (ack_wait >= 0 && r_nreq == ack_wait + 1) begin
            dm_if.dm_ack   = 1'b1;
            dm_if.dm_rdata = word;
          end
        end
      end
    end
    if (!got) chk("done_bound", 32'd0, 32'd1);
  endtask

  initial begin
    int seen_done;
    rst = 1'b1;
    req_valid = 1'b0;
    mem_op = 4'd0;
    addr = 32'd0;
    wdata = 32'd0;
    dm_if.dm_ack = 1'b0;
    dm_if.dm_rdata = 32'd0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_done",      {31'd0, done}, 32'd0);
    chk("rst_rdata",     rdata, 32'd0);
    chk("rst_misalign",  {31'd0, misalign}, 32'd0);
    chk("rst_bus_err",   {31'd0, bus_err}, 32'd0);
    chk("rst_dm_req",    {31'd0, dm_if.dm_req}, 32'd0);
    chk("rst_dm_we",     {31'd0, dm_if.dm_we}, 32'd0);
    chk("rst_dm_be",     {28'd0, dm_if.dm_be}, 32'd0);
    chk("rst_dm_addr",   dm_if.dm_addr, 32'd0);
    chk("rst_dm_wdata",  dm_if.dm_wdata, 32'd0);
    chk("rst_state",     {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;

    // SW, zero-wait memory
    run_op(LSU_SW, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    chk("sw_done_cyc", r_done_cyc, 2);
    chk("sw_nreq",     r_nreq, 1);
    chk("sw_stall",    {31'd0, r_stall_ok}, 32'd1);
    chk("sw_we",       {31'd0, r_we}, 32'd1);
    chk("sw_be",       {28'd0, r_be}, 32'hF);
    chk("sw_addr",     r_addr, 32'h100);
    chk("sw_wdata",    r_wdata, 32'hDEADBEEF);
    chk("sw_req_off",  {31'd0, dm_if.dm_req}, 32'd0);
    chk("sw_misalign", {31'd0, misalign}, 32'd0);
    chk("sw_bus_err",  {31'd0, bus_err}, 32'd0);

    run_op(LSU_SB, 32'h103, 32'h000000A5, 0, 32'h0);
    chk("sb_be",    {28'd0, r_be}, 32'h8);
    chk("sb_wdata", r_wdata, 32'hA5A5A5A5);
    chk("sb_addr",  r_addr, 32'h100);

    run_op(LSU_SH, 32'h102, 32'h1234BEEF, 1, 32'h0);
    chk("sh_be",       {28'd0, r_be}, 32'hC);
    chk("sh_wdata",    r_wdata, 32'hBEEFBEEF);
    chk("sh_done_cyc", r_done_cyc, 3);

    run_op(LSU_LB, 32'h102, 32'h0, 0, 32'h12F45678);
    chk("lb_rdata",    rdata, 32'hFFFFFFF4);
    chk("lb_we",       {31'd0, r_we}, 32'd0);
    chk("lb_be",       {28'd0, r_be}, 32'hF);
    chk("lb_done_cyc", r_done_cyc, 2);

    run_op(LSU_LBU, 32'h102, 32'h0, 0, 32'h12F45678);
    chk("lbu_rdata", rdata, 32'h000000F4);

    run_op(LSU_LH, 32'h100, 32'h0, 2, 32'h00008001);
    chk("lh_rdata",    rdata, 32'hFFFF8001);
    chk("lh_done_cyc", r_done_cyc, 4);

    run_op(LSU_LHU, 32'h102, 32'h0, 0, 32'h80010000);
    chk("lhu_rdata", rdata, 32'h00008001);

    // ack lands in the same cycle the timeout would fire
    run_op(LSU_LW, 32'h104, 32'h0, 3, 32'hCAFEF00D);
    chk("lw_edge_rdata",    rdata, 32'hCAFEF00D);
    chk("lw_edge_bus_err",  {31'd0, bus_err}, 32'd0);
    chk("lw_edge_done_cyc", r_done_cyc, 5);
    chk("lw_edge_nreq",     r_nreq, 4);

    run_op(LSU_SB, 32'h100, 32'h00000077, 0, 32'h0);
    chk("sb_rdata_hold", rdata, 32'hCAFEF00D);

    run_op(LSU_LH, 32'h101, 32'h0, 0, 32'h0);
    chk("lh_mis_flag",     {31'd0, misalign}, 32'd1);
    chk("lh_mis_done_cyc", r_done_cyc, 1);
    chk("lh_mis_nreq",     r_nreq, 0);
    chk("lh_mis_rdata",    rdata, 32'hCAFEF00D);

    run_op(LSU_SW, 32'h102, 32'h11111111, 0, 32'h0);
    chk("sw_mis_flag", {31'd0, misalign}, 32'd1);
    chk("sw_mis_nreq", r_nreq, 0);

    run_op(LSU_NONE, 32'h200, 32'h0, 0, 32'h0);
    chk("none_done_cyc", r_done_cyc, 1);
    chk("none_nreq",     r_nreq, 0);
    chk("none_misalign", {31'd0, misalign}, 32'd0);
    chk("none_rdata",    rdata, 32'hCAFEF00D);

    run_op(LSU_LW, 32'h108, 32'h0, -1, 32'h0);
    chk("to_bus_err",  {31'd0, bus_err}, 32'd1);
    chk("to_rdata",    rdata, 32'd0);
    chk("to_done_cyc", r_done_cyc, 5);
    chk("to_nreq",     r_nreq, 4);

    run_op(LSU_LB, 32'h101, 32'h0, 0, 32'h12F45678);
    chk("lb1_rdata",   rdata, 32'h00000056);
    chk("lb1_bus_err", {31'd0, bus_err}, 32'd0);

    // reset in the middle of an access
    @(negedge clk);
    req_valid = 1'b1;
    mem_op    = LSU_LW;
    addr      = 32'h200;
    @(negedge clk);
    chk("rstmid_req_before", {31'd0, dm_if.dm_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_req_after", {31'd0, dm_if.dm_req}, 32'd0);
    chk("rstmid_state",     {30'd0, dbg_state}, {30'd0, ST_IDLE});
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("rstmid_no_done", seen_done, 0);
    req_valid = 1'b0;
    mem_op    = 4'd0;
    @(negedge clk);
    rst = 1'b0;

    run_op(LSU_LW, 32'h10C, 32'h0, 0, 32'h0BADC0DE);
    chk("post_rst_rdata",    rdata, 32'h0BADC0DE);
    chk("post_rst_done_cyc", r_done_cyc, 2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store stage sitting directly downstream of the ALU. It takes the ALU result as an effective address plus rt as store data and runs one data-memory transaction over a req/ack bus: byte-lane steering, store data replication, load extraction and sign/zero extension, misalignment and ack-timeout detection. It raises `stall` so the core holds PC and writeback until the access completes.

## Interface
- `ACK_TIMEOUT`, 255: cycles in ACCESS without `dm_ack` before `bus_err` is raised; range 1..255.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: core requests an access; held high until `done`.
- `mem_op` in 4: `LSU_*` opcode: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- `addr` in 32: effective address (ALU result C).
- `wdata` in 32: store data (rt).
- `req_ready` out 1: high in IDLE only.
- `stall` out 1: `req_valid & ~done`, combinational.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result; valid with `done`, held until the next accept.
- `misalign` out 1: valid with `done`.
- `bus_err` out 1: valid with `done`.
- `dm_req` out 1: bus request level.
- `dm_we` out 1: write strobe.
- `dm_be` out 4: byte enables, bit i = byte lane i (little-endian).
- `dm_addr` out 32: `{addr[31:2],2'b00}`.
- `dm_wdata` out 32: lane-steered store data.
- `dm_ack` in 1: memory ack; read data valid the same cycle.
- `dm_rdata` in 32: memory read word.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, accept when `req_valid & req_ready`: latch op/addr/wdata.
  - NONE: go to RESP, no bus access, `rdata` unchanged.
  - Misaligned (H ops with `addr[0]`=1, W ops with `addr[1:0]`≠0): go to RESP with `misalign`=1, no bus access.
  - Otherwise: go to ACCESS.
- ACCESS: `dm_req`=1 and all `dm_*` outputs stable.
  - Timeout counter clears on entry and increments each cycle.
  - On `dm_ack`: capture the extended load value (loads) and go to RESP.
  - When the count reaches `ACK_TIMEOUT` with no ack: `bus_err`=1, `rdata`=0, go to RESP.
  - An ack in the same cycle as the timeout wins.
- RESP: `done`=1 for exactly one cycle, then IDLE. `misalign` and `bus_err` clear on the next accept.
- Store lanes:
  - SB: `dm_be` = `4'b0001 << addr[1:0]`, `dm_wdata` = `{4{wdata[7:0]}}`.
  - SH: `dm_be` = `addr[1] ? 4'b1100 : 4'b0011`, `dm_wdata` = `{2{wdata[15:0]}}`.
  - SW: `dm_be` = `4'b1111`.
- Loads: `dm_we`=0, `dm_be`=1111. Select the byte/half by `addr[1:0]` / `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend.
- `req_valid` dropping mid-access is ignored; the access completes.

## Timing
- Reset values: `req_ready`=1, `done`=0, `rdata`=0, `misalign`=0, `bus_err`=0, all `dm_*`=0, state IDLE.
- Reset mid-ACCESS drops `dm_req` immediately; no `done` is issued.
- Accept at edge 0 → `dm_req` high in cycle 1.
- Ack in cycle k → `done` in cycle k+1. Zero-wait memory gives a 2-cycle access.
- NONE and misaligned ops: `done` in cycle 1.
- Back-to-back: the next accept is possible in the cycle after `done`.
- `dm_req` is registered, never combinational from `req_valid`.

## Structure
- `LSU_NONE` .. `LSU_SW` opcode defines and the state encodings go in `ctrl_encode_def.v`, alongside the ALU op defines.
- One combinational sub-module, `load_extend`: inputs word, `addr[1:0]`, op; output the 32-bit extended result. It is reused by the writeback mux.

## Test plan
- SW `addr`=0x100, `wdata`=0xDEADBEEF, ack in cycle 1 → `dm_be`=1111, `dm_addr`=0x100, `done` in cycle 2, `stall` high cycles 0-1.
- SB `addr`=0x103, `wdata`=0x000000A5 → `dm_be`=1000, `dm_wdata`=0xA5A5A5A5.
- LB/LBU `addr`=0x102, `dm_rdata`=0x12F45678 → `rdata` 0xFFFFFFF4 / 0x000000F4.
- LH `addr`=0x101 → `misalign`=1 and `done` in cycle 1, `dm_req` never high.
- LW with no ack, `ACK_TIMEOUT`=4 → `bus_err`=1, `rdata`=0, `done` after 4 ACCESS cycles.
- `rst` asserted during ACCESS → `dm_req`=0 the same cycle, no `done`. A fresh LW after release completes normally.
